// File: rtl/output_uart_pkg.sv
// Shared types and constants for the outputLine UART transmitter.
package output_uart_pkg;

   localparam int unsigned UART_DATA_BITS      = 8;
   localparam int unsigned UART_BYTES_PER_WORD = 2;
   localparam int unsigned WORD_W              = UART_DATA_BITS * UART_BYTES_PER_WORD;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } uartState_e;

   // Byte 0 is the low byte, which goes out first.
   function automatic logic [UART_DATA_BITS-1:0] selectByte(input logic [WORD_W-1:0] word,
                                                            input logic byteIdx);
      return byteIdx ? word[WORD_W-1:UART_DATA_BITS] : word[UART_DATA_BITS-1:0];
   endfunction

endpackage

// File: rtl/io_word_fifo.sv
// Synchronous word FIFO with count; active-low synchronous reset clears pointers and count.
module io_word_fifo
   import output_uart_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WORD_W-1:0]        pushData,
   input  logic                     pop,
   output logic [WORD_W-1:0]        popData,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

   logic [WORD_W-1:0] mem [DEPTH];
   logic [PtrW-1:0]   wrPtrQ;
   logic [PtrW-1:0]   rdPtrQ;
   logic [PtrW:0]     countQ;
   logic              wrEn;
   logic              rdEn;

   assign full  = (countQ == FullCount);
   assign empty = (countQ == '0);
   assign rdEn  = pop & ~empty;
   // A pop in the same cycle frees the slot a full FIFO needs.
   assign wrEn  = push & (~full | rdEn);

   always_ff @(posedge clk) begin
      if (!rst) begin
         wrPtrQ <= '0;
         rdPtrQ <= '0;
         countQ <= '0;
      end else begin
         if (wrEn) wrPtrQ <= wrPtrQ + 1'b1;
         if (rdEn) rdPtrQ <= rdPtrQ + 1'b1;
         if (wrEn && !rdEn) begin
            countQ <= countQ + 1'b1;
         end else if (rdEn && !wrEn) begin
            countQ <= countQ - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wrEn) mem[wrPtrQ] <= pushData;
   end

   assign popData = mem[rdPtrQ];
   assign count   = countQ;

endmodule

// File: rtl/output_line_uart_tx.sv
// Queues every change of outputLine and sends each word as two UART bytes, low byte first.
// Defining OUTPUT_UART_PARITY_EN adds an even-parity bit after the data bits.
module output_line_uart_tx
   import output_uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned FIFO_DEPTH   = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [WORD_W-1:0]             outputLine,
   output logic                          tx,
   output logic                          busy,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
   localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);
   localparam int unsigned IdxW = $clog2(UART_DATA_BITS);
   localparam logic [IdxW-1:0] IdxMax = IdxW'(UART_DATA_BITS - 1);

   logic [WORD_W-1:0]          prevQ;
   uartState_e                 stateQ, stateD;
   logic [WORD_W-1:0]          holdQ, holdD;
   logic                       byteIdxQ, byteIdxD;
   logic [IdxW-1:0]            bitIdxQ, bitIdxD;
   logic [CntW-1:0]            bitCntQ, bitCntD;
   logic                       txQ, txD;
   logic                       overflowQ;

   logic                       lineChanged;
   logic                       pop;
   logic                       fifoFull;
   logic                       fifoEmpty;
   logic [WORD_W-1:0]          fifoData;
   logic                       bitDone;
   logic [UART_DATA_BITS-1:0]  curByte;

   assign lineChanged = (outputLine != prevQ);
   assign bitDone     = (bitCntQ == CntMax);

   io_word_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) uFifo (
      .clk      (clk),
      .rst      (rst),
      .push     (lineChanged),
      .pushData (outputLine),
      .pop      (pop),
      .popData  (fifoData),
      .full     (fifoFull),
      .empty    (fifoEmpty),
      .count    (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         prevQ     <= '0;
         stateQ    <= StIdle;
         holdQ     <= '0;
         byteIdxQ  <= 1'b0;
         bitIdxQ   <= '0;
         bitCntQ   <= '0;
         txQ       <= 1'b1;
         overflowQ <= 1'b0;
      end else begin
         prevQ    <= outputLine;
         stateQ   <= stateD;
         holdQ    <= holdD;
         byteIdxQ <= byteIdxD;
         bitIdxQ  <= bitIdxD;
         bitCntQ  <= bitCntD;
         txQ      <= txD;
         // Dropped push: full with no pop to make room this cycle.
         if (lineChanged && fifoFull && !pop) overflowQ <= 1'b1;
      end
   end

   always_comb begin
      stateD   = stateQ;
      holdD    = holdQ;
      byteIdxD = byteIdxQ;
      bitIdxD  = bitIdxQ;
      bitCntD  = bitCntQ;
      pop      = 1'b0;

      unique case (stateQ)
         StIdle: begin
            if (!fifoEmpty) begin
               pop      = 1'b1;
               holdD    = fifoData;
               byteIdxD = 1'b0;
               bitCntD  = '0;
               stateD   = StStart;
            end
         end

         StStart: begin
            if (bitDone) begin
               bitCntD = '0;
               bitIdxD = '0;
               stateD  = StData;
            end else begin
               bitCntD = bitCntQ + 1'b1;
            end
         end

         StData: begin
            if (bitDone) begin
               bitCntD = '0;
               if (bitIdxQ == IdxMax) begin
`ifdef OUTPUT_UART_PARITY_EN
                  stateD = StParity;
`else
                  stateD = StStop;
`endif
               end else begin
                  bitIdxD = bitIdxQ + 1'b1;
               end
            end else begin
               bitCntD = bitCntQ + 1'b1;
            end
         end

`ifdef OUTPUT_UART_PARITY_EN
         StParity: begin
            if (bitDone) begin
               bitCntD = '0;
               stateD  = StStop;
            end else begin
               bitCntD = bitCntQ + 1'b1;
            end
         end
`endif

         StStop: begin
            if (bitDone) begin
               bitCntD = '0;
               if (!byteIdxQ) begin
                  byteIdxD = 1'b1;
                  stateD   = StStart;
               end else if (!fifoEmpty) begin
                  // Next word starts with no idle gap.
                  pop      = 1'b1;
                  holdD    = fifoData;
                  byteIdxD = 1'b0;
                  stateD   = StStart;
               end else begin
                  stateD = StIdle;
               end
            end else begin
               bitCntD = bitCntQ + 1'b1;
            end
         end

         default: stateD = StIdle;
      endcase

      // tx is registered, so it is derived from the state being entered.
      curByte = selectByte(holdD, byteIdxD);
      case (stateD)
         StStart:  txD = 1'b0;
         StData:   txD = curByte[bitIdxD];
         StParity: txD = ^curByte;
         default:  txD = 1'b1;
      endcase
   end

   assign tx       = txQ;
   assign overflow = overflowQ;
   assign busy     = (stateQ != StIdle) | (fifo_count != '0);

endmodule

// File: tb/tb_output_line_uart_tx.sv
// Self-checking bench for output_line_uart_tx: table-driven frames, corner sequences and a
// randomized run checked by an independent UART receiver model.
module tb_output_line_uart_tx;

   localparam int unsigned C = 4;
   localparam int unsigned D = 8;
`ifdef OUTPUT_UART_PARITY_EN
   localparam int unsigned F = 11;
`else
   localparam int unsigned F = 10;
`endif

   typedef struct {
      logic [15:0] word;
      logic [7:0]  lo;
      logic [7:0]  hi;
      logic        parLo;
      logic        parHi;
   } vec_t;

   logic        clk = 1'b0;
   logic        rstN;
   logic [15:0] outputLine;
   logic        tx;
   logic        busy;
   logic        overflow;
   logic [3:0]  fifoCount;

   int          nVec = 0;
   int          nErr = 0;
   int          rstCount = 0;
   logic [7:0]  rxBytes[$];
   logic [15:0] curLine;
   vec_t        vecs[7];

   always #5 clk = ~clk;

   output_line_uart_tx #(
      .CLKS_PER_BIT (C),
      .FIFO_DEPTH   (D)
   ) dut (
      .clk        (clk),
      .rst        (rstN),
      .outputLine (outputLine),
      .tx         (tx),
      .busy       (busy),
      .overflow   (overflow),
      .fifo_count (fifoCount)
   );

   always @(posedge clk) begin
      if (!rstN) rstCount <= rstCount + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nVec++;
      if (act !== exp) begin
         nErr++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Receiver model: finds a start bit, samples mid-bit, queues each byte.
   initial begin : rxMon
      logic [7:0] rb;
      logic       sb;
      logic       pb;
      int         rc0;
      pb = 1'b0;
      forever begin
         @(negedge clk);
         if (rstN === 1'b1 && tx === 1'b0) begin
            rc0 = rstCount;
            repeat (C / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (C) @(negedge clk);
               rb[i] = tx;
            end
`ifdef OUTPUT_UART_PARITY_EN
            repeat (C) @(negedge clk);
            pb = tx;
`endif
            repeat (C) @(negedge clk);
            sb = tx;
            if (rstCount == rc0) begin
               check("rxStopBit", 32'(sb), 32'(1));
`ifdef OUTPUT_UART_PARITY_EN
               check("rxParity", 32'(pb), 32'(^rb));
`endif
               rxBytes.push_back(rb);
            end
         end
      end
   end

   task automatic waitIdle(input int limit);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      check("idleWithinBudget", 32'(busy), 32'(0));
      repeat (2) @(negedge clk);
   endtask

   // Drive one change and check exact frame timing bit by bit.
   task automatic sendAndCheck(input vec_t v);
      int         cyc;
      int         t;
      logic [7:0] byteV;
      logic       expb;
`ifdef OUTPUT_UART_PARITY_EN
      logic       par;
`endif
      outputLine = v.word;
      curLine    = v.word;
      @(negedge clk);
      check($sformatf("cntAfterPush %h", v.word), 32'(fifoCount), 32'(1));
      check("busyAfterPush", 32'(busy), 32'(1));
      check("txBeforePop", 32'(tx), 32'(1));
      @(negedge clk);
      check("cntAfterPop", 32'(fifoCount), 32'(0));
      cyc = 0;
      for (int b = 0; b < 2; b++) begin
         byteV = (b == 0) ? v.lo : v.hi;
`ifdef OUTPUT_UART_PARITY_EN
         par = (b == 0) ? v.parLo : v.parHi;
`endif
         for (int j = 0; j < int'(F); j++) begin
            if (j == 0) expb = 1'b0;
            else if (j <= 8) expb = byteV[j-1];
`ifdef OUTPUT_UART_PARITY_EN
            else if (j == 9) expb = par;
`endif
            else expb = 1'b1;
            t = (b * int'(F) + j) * int'(C) + int'(C / 2);
            while (cyc < t) begin
               @(negedge clk);
               cyc++;
            end
            check($sformatf("frame %h byte%0d bit%0d", v.word, b, j), 32'(tx), 32'(expb));
         end
      end
      while (cyc < 2 * int'(F) * int'(C) - 1) begin
         @(negedge clk);
         cyc++;
      end
      check("busyLastStopCycle", 32'(busy), 32'(1));
      @(negedge clk);
      check("busyAfterWord", 32'(busy), 32'(0));
      check("txAfterWord", 32'(tx), 32'(1));
   endtask

   task automatic randomPhase();
      logic [15:0] expQ[$];
      logic [15:0] v;
      logic [15:0] got;
      int          n;
      int          nw;
      rxBytes.delete();
      for (int b = 0; b < 12; b++) begin
         n = $urandom_range(1, 6);
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) v = curLine;
            else v = 16'($urandom());
            if (v != curLine) expQ.push_back(v);
            outputLine = v;
            curLine    = v;
            repeat ($urandom_range(1, 40)) @(negedge clk);
         end
         waitIdle(6 * 2 * int'(F) * int'(C) + 100);
      end
      check("randWordCount", 32'(rxBytes.size()), 32'(2 * expQ.size()));
      nw = (rxBytes.size() / 2 < expQ.size()) ? rxBytes.size() / 2 : expQ.size();
      for (int i = 0; i < nw; i++) begin
         got = {rxBytes[2*i+1], rxBytes[2*i]};
         check($sformatf("randWord%0d", i), 32'(got), 32'(expQ[i]));
      end
      check("randNoOverflow", 32'(overflow), 32'(0));
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: time limit reached, vectors=%0d", nVec);
      $fatal(1, "simulation timed out");
   end

   initial begin : main
      int          sz;
      logic [15:0] got;
      vec_t        v;

      vecs[0] = '{16'hA55A, 8'h5A, 8'hA5, 1'b0, 1'b0};
      vecs[1] = '{16'h0301, 8'h01, 8'h03, 1'b1, 1'b0};
      vecs[2] = '{16'hFFFF, 8'hFF, 8'hFF, 1'b0, 1'b0};
      vecs[3] = '{16'h0000, 8'h00, 8'h00, 1'b0, 1'b0};
      vecs[4] = '{16'h8001, 8'h01, 8'h80, 1'b1, 1'b1};
      vecs[5] = '{16'h00FF, 8'hFF, 8'h00, 1'b0, 1'b0};
      vecs[6] = '{16'h1234, 8'h34, 8'h12, 1'b1, 1'b0};

      // Reset values, line held non-zero during reset.
      rstN       = 1'b0;
      outputLine = 16'h1234;
      curLine    = 16'h0000;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("txDuringReset", 32'(tx), 32'(1));
      end
      check("busyReset", 32'(busy), 32'(0));
      check("overflowReset", 32'(overflow), 32'(0));
      check("cntReset", 32'(fifoCount), 32'(0));
      outputLine = 16'h0000;
      rstN       = 1'b1;
      repeat (5) @(negedge clk);
      check("zeroLineIdleBusy", 32'(busy), 32'(0));
      check("zeroLineIdleCnt", 32'(fifoCount), 32'(0));
      check("nothingSentAtReset", 32'(rxBytes.size()), 32'(0));

      // Table of single words with exact frame timing.
      for (int i = 0; i < 7; i++) begin
         sendAndCheck(vecs[i]);
         repeat (3) @(negedge clk);
      end
      check("tableBytesReceived", 32'(rxBytes.size()), 32'(14));

      // Held value: no further words, FIFO stays empty.
      sz = rxBytes.size();
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         check("heldCnt", 32'(fifoCount), 32'(0));
      end
      check("heldNoExtraBytes", 32'(rxBytes.size()), 32'(sz));

      // Overflow: 10 consecutive distinct values.
      rxBytes.delete();
      check("overflowBefore", 32'(overflow), 32'(0));
      for (int i = 0; i < 10; i++) begin
         outputLine = 16'hC000 + 16'(i);
         @(negedge clk);
         if (i == 8) begin
            check("ovfCountFull", 32'(fifoCount), 32'(8));
            check("ovfNotYet", 32'(overflow), 32'(0));
         end
      end
      curLine = 16'hC009;
      check("ovfSet", 32'(overflow), 32'(1));
      check("ovfCountHeld", 32'(fifoCount), 32'(8));
      waitIdle(9 * 2 * int'(F) * int'(C) + 100);
      check("ovfSticky", 32'(overflow), 32'(1));
      check("ovfWordCount", 32'(rxBytes.size()), 32'(18));
      for (int i = 0; i < 9 && 2 * i + 1 < rxBytes.size(); i++) begin
         got = {rxBytes[2*i+1], rxBytes[2*i]};
         check($sformatf("ovfWord%0d", i), 32'(got), 32'(16'hC000 + 16'(i)));
      end

      // Reset during DATA of the low byte with 3 words queued.
      for (int i = 0; i < 4; i++) begin
         outputLine = 16'hD001 + 16'(i);
         @(negedge clk);
      end
      repeat (3 * C - 2) @(negedge clk);
      check("midFrameQueued", 32'(fifoCount), 32'(3));
      check("midFrameTxLowData", 32'(busy), 32'(1));
      rstN       = 1'b0;
      outputLine = 16'h0000;
      curLine    = 16'h0000;
      @(negedge clk);
      check("abortTx", 32'(tx), 32'(1));
      check("abortCnt", 32'(fifoCount), 32'(0));
      check("abortBusy", 32'(busy), 32'(0));
      check("abortOverflowClr", 32'(overflow), 32'(0));
      rstN = 1'b1;
      repeat (100) @(negedge clk);
      rxBytes.delete();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         check("quietAfterAbort", 32'(tx), 32'(1));
      end
      check("abortNothingSent", 32'(rxBytes.size()), 32'(0));
      v = '{16'h5AA5, 8'hA5, 8'h5A, 1'b0, 1'b0};
      sendAndCheck(v);
      repeat (3) @(negedge clk);

      // Randomized traffic against the receiver model.
      randomPhase();

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule
